// File: rtl/pic_ctrl.sv
// Programmable interrupt controller: per-channel edge/level sources, mask, pending,
// nested in-service priority with EOI, registered INT and a vector on intack.
module pic_ctrl #(
    parameter int                 NUM_IRQ      = 8,
    parameter int                 DATA_W       = 16,
    parameter int                 ADDR_W       = 12,
    parameter logic [ADDR_W-1:0]  BASE_ADDR    = 12'hA00,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK    = {NUM_IRQ{1'b1}},
    parameter logic [DATA_W-1:0]  SPURIOUS_VEC = 16'hFFFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [ADDR_W-1:0]  address,
    input  logic [DATA_W-1:0]  data_wr,
    input  logic               memwt,
    input  logic               intack,
    output logic [DATA_W-1:0]  data_rd,
    output logic               sel,
    output logic               INT
);
    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    logic [NUM_IRQ-1:0] mask_q, pend_q, in_service_q, irq_prev_q;
    logic               int_q;

    logic [ADDR_W-1:0]  offset;
    logic [2:0]         reg_sel;
    logic               wr_en, eoi, ack;
    logic [NUM_IRQ-1:0] pend_view, is_lsb, below_is, eligible, win_oh;
    logic [NUM_IRQ-1:0] rise, w1c_clr, ack_oh, eoi_clr;
    logic [IDX_W-1:0]   win_idx;
    logic               win_vld;
    logic [DATA_W-1:0]  vector, rd_reg;
    logic               unused_hi;

    assign offset  = address - BASE_ADDR;
    assign sel     = (address >= BASE_ADDR) && (offset < ADDR_W'(8));
    assign reg_sel = offset[2:0];
    assign wr_en   = memwt && sel;
    assign eoi     = wr_en && (reg_sel == 3'd3);

    // Level channels are never latched: their pending view is the live input.
    assign pend_view = (pend_q & EDGE_MASK) | (irq & ~EDGE_MASK);
    assign is_lsb    = in_service_q & (~in_service_q + NUM_IRQ'(1));
    assign below_is  = is_lsb - NUM_IRQ'(1);
    assign eligible  = pend_view & mask_q & below_is;

    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        win_oh  = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'(i);
                win_oh  = '0;
                win_oh[i] = 1'b1;
            end
        end
    end

    assign ack     = intack && win_vld;
    assign ack_oh  = ack ? win_oh : '0;
    assign eoi_clr = eoi ? is_lsb : '0;
    assign rise    = irq & ~irq_prev_q & EDGE_MASK;
    assign w1c_clr = (wr_en && (reg_sel == 3'd1)) ? data_wr[NUM_IRQ-1:0] : '0;
    assign vector  = win_vld ? DATA_W'(win_idx) : SPURIOUS_VEC;

    always_comb begin
        rd_reg = '0;
        case (reg_sel)
            3'd0:    rd_reg[NUM_IRQ-1:0] = mask_q;
            3'd1:    rd_reg[NUM_IRQ-1:0] = pend_view;
            3'd2:    rd_reg[NUM_IRQ-1:0] = in_service_q;
            3'd4:    rd_reg = vector;
            default: rd_reg = '0;
        endcase
    end

    assign data_rd   = intack ? vector : (sel ? rd_reg : '0);
    assign INT       = int_q;
    assign unused_hi = ^(data_wr >> NUM_IRQ);

    // The acknowledged winner is the lowest eligible index, so once it enters
    // service nothing left can outrank it: INT drops on the ack edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q       <= '0;
            pend_q       <= '0;
            in_service_q <= '0;
            irq_prev_q   <= '0;
            int_q        <= 1'b0;
        end else begin
            irq_prev_q   <= irq;
            pend_q       <= ((pend_q & ~w1c_clr & ~ack_oh) | rise) & EDGE_MASK;
            in_service_q <= (in_service_q & ~eoi_clr) | ack_oh;
            int_q        <= win_vld && !ack;
            if (wr_en && (reg_sel == 3'd0))
                mask_q <= data_wr[NUM_IRQ-1:0];
        end
    end
endmodule

// File: tb/tb_pic_ctrl.sv
// Bench for pic_ctrl: reset read table, directed multi-cycle sequences,
// then randomized traffic against a behavioural reference model.
module tb_pic_ctrl;
    localparam logic [11:0] BASE = 12'hA00;
    localparam logic [7:0]  EDGE = 8'hEF;

    logic        clk, reset, memwt, intack, sel, INT;
    logic [7:0]  irq;
    logic [11:0] address;
    logic [15:0] data_wr, data_rd, d;
    int          n_cmp, n_bad;

    pic_ctrl #(.NUM_IRQ(8), .DATA_W(16), .ADDR_W(12), .BASE_ADDR(BASE),
               .EDGE_MASK(EDGE), .SPURIOUS_VEC(16'hFFFF)) dut (
        .clk(clk), .reset(reset), .irq(irq), .address(address), .data_wr(data_wr),
        .memwt(memwt), .intack(intack), .data_rd(data_rd), .sel(sel), .INT(INT));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] addr;
        logic        exp_sel;
        logic [15:0] exp_rd;
    } rd_vec_t;
    rd_vec_t tbl[10];

    // Reference model state.
    logic [7:0] m_mask, m_pend, m_is, m_prev;
    logic       m_int;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [15:0] v);
        address = a; data_wr = v; memwt = 1'b1;
        tick();
        memwt = 1'b0; address = 12'h000;
    endtask

    task automatic rd(input logic [11:0] a, output logic [15:0] v);
        address = a;
        #1;
        v = data_rd;
    endtask

    function automatic logic m_sel(input logic [11:0] a);
        return (a >= BASE) && (a <= BASE + 12'd7);
    endfunction

    function automatic logic [7:0] m_view();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = EDGE[i] ? m_pend[i] : irq[i];
        return v;
    endfunction

    // Lowest masked pending channel strictly above (in priority) every channel in service.
    function automatic int m_winner(input logic [7:0] pv, input logic [7:0] mk, input logic [7:0] is);
        int lim;
        lim = 8;
        for (int i = 7; i >= 0; i--) if (is[i]) lim = i;
        for (int i = 0; i < lim; i++) if (pv[i] && mk[i]) return i;
        return -1;
    endfunction

    function automatic logic [15:0] m_rd();
        int         w;
        logic [7:0] pv;
        logic [15:0] vec;
        logic [11:0] off;
        pv  = m_view();
        w   = m_winner(pv, m_mask, m_is);
        vec = (w >= 0) ? 16'(w) : 16'hFFFF;
        if (intack) return vec;
        if (!m_sel(address)) return 16'h0000;
        off = address - BASE;
        case (off)
            12'd0:   return {8'h00, m_mask};
            12'd1:   return {8'h00, pv};
            12'd2:   return {8'h00, m_is};
            12'd4:   return vec;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic m_step();
        int          w;
        logic        acked, wok, cleared;
        logic [11:0] off;
        logic [7:0]  is_n, pend_n;
        w     = m_winner(m_view(), m_mask, m_is);
        acked = intack && (w >= 0);
        wok   = memwt && m_sel(address);
        off   = address - BASE;
        is_n  = m_is;
        pend_n = m_pend;
        if (wok && off == 12'd3) begin
            cleared = 1'b0;
            for (int i = 0; i < 8; i++)
                if (is_n[i] && !cleared) begin is_n[i] = 1'b0; cleared = 1'b1; end
        end
        if (wok && off == 12'd1) pend_n = pend_n & ~data_wr[7:0];
        if (acked) begin
            is_n[w]   = 1'b1;
            pend_n[w] = 1'b0;
        end
        for (int i = 0; i < 8; i++)
            if (EDGE[i] && irq[i] && !m_prev[i]) pend_n[i] = 1'b1;
        // After an ack, the new in-service level hides everything that was eligible.
        m_int  = (m_winner(m_view(), m_mask, acked ? (m_is | (8'h01 << w)) : m_is) >= 0);
        m_pend = pend_n & EDGE;
        m_is   = is_n;
        m_prev = irq;
        if (wok && off == 12'd0) m_mask = data_wr[7:0];
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        reset = 1'b1; irq = '0; address = '0; data_wr = '0; memwt = 1'b0; intack = 1'b0;
        tbl[0] = '{BASE + 12'd0, 1'b1, 16'h0000};
        tbl[1] = '{BASE + 12'd1, 1'b1, 16'h0000};
        tbl[2] = '{BASE + 12'd2, 1'b1, 16'h0000};
        tbl[3] = '{BASE + 12'd3, 1'b1, 16'h0000};
        tbl[4] = '{BASE + 12'd4, 1'b1, 16'hFFFF};
        tbl[5] = '{BASE + 12'd5, 1'b1, 16'h0000};
        tbl[6] = '{BASE + 12'd7, 1'b1, 16'h0000};
        tbl[7] = '{BASE + 12'd8, 1'b0, 16'h0000};
        tbl[8] = '{BASE - 12'd1, 1'b0, 16'h0000};
        tbl[9] = '{12'h000,      1'b0, 16'h0000};
        #12;
        chk("reset_int", INT, 0);
        reset = 1'b0;
        tick(); tick();
        chk("idle_int", INT, 0);
        foreach (tbl[i]) begin
            rd(tbl[i].addr, d);
            chk($sformatf("tbl%0d_sel", i), sel, tbl[i].exp_sel);
            chk($sformatf("tbl%0d_rd", i), d, tbl[i].exp_rd);
        end

        // Single edge request: latency, vector, ack effects.
        wr(BASE, 16'h00FF);
        irq = 8'h04; tick(); irq = 8'h00;
        chk("lat_k", INT, 0);
        tick();
        chk("lat_k1", INT, 1);
        intack = 1'b1; #1;
        chk("vec2", data_rd, 16'h0002);
        tick(); intack = 1'b0;
        chk("ack_int", INT, 0);
        rd(BASE + 12'd2, d); chk("ack_is", d, 16'h0004);
        rd(BASE + 12'd1, d); chk("ack_pend", d, 16'h0000);

        // Two simultaneous requests, priority then EOI.
        wr(BASE + 12'd3, 16'h0000);
        irq = 8'h22; tick(); irq = 8'h00; tick();
        chk("two_int", INT, 1);
        intack = 1'b1; #1; chk("vec1", data_rd, 16'h0001);
        tick(); intack = 1'b0;
        chk("nest_int", INT, 0);
        wr(BASE + 12'd3, 16'h0000); tick();
        chk("eoi_int", INT, 1);
        intack = 1'b1; #1; chk("vec5", data_rd, 16'h0005);
        tick(); intack = 1'b0;
        rd(BASE + 12'd2, d); chk("is_20", d, 16'h0020);

        // Nesting under channel 5.
        irq = 8'h40; tick(); irq = 8'h00; tick(); tick();
        chk("low_blk_int", INT, 0);
        rd(BASE + 12'd1, d); chk("pend6", d, 16'h0040);
        irq = 8'h08; tick(); irq = 8'h00; tick();
        chk("hi_int", INT, 1);
        intack = 1'b1; #1; chk("vec3", data_rd, 16'h0003);
        tick(); intack = 1'b0;
        rd(BASE + 12'd2, d); chk("is_28", d, 16'h0028);
        wr(BASE + 12'd3, 16'h0000);
        rd(BASE + 12'd2, d); chk("eoi_lsb", d, 16'h0020);
        wr(BASE + 12'd3, 16'h0000);
        rd(BASE + 12'd2, d); chk("eoi_zero", d, 16'h0000);
        tick(); chk("held6_int", INT, 1);
        wr(BASE + 12'd1, 16'hFFFF); tick();
        chk("w1c_int", INT, 0);
        rd(BASE + 12'd1, d); chk("w1c_pend", d, 16'h0000);

        // Level channel 4.
        wr(BASE, 16'h00EF);
        irq = 8'h10; tick(); tick();
        chk("lvl_masked", INT, 0);
        rd(BASE + 12'd1, d); chk("lvl_pend", d, 16'h0010);
        wr(BASE, 16'h00FF);
        chk("mask_next_edge", INT, 0);
        tick(); chk("lvl_int", INT, 1);
        intack = 1'b1; #1; chk("vec4", data_rd, 16'h0004);
        tick(); intack = 1'b0;
        chk("lvl_ack_int", INT, 0);
        wr(BASE + 12'd3, 16'h0000); tick();
        chk("lvl_reassert", INT, 1);
        irq = 8'h00;
        rd(BASE + 12'd1, d); chk("lvl_drop", d, 16'h0000);
        tick(); tick();
        chk("lvl_int_low", INT, 0);

        // Spurious acknowledge.
        address = 12'h000; intack = 1'b1; #1;
        chk("spur_vec", data_rd, 16'hFFFF);
        tick(); intack = 1'b0;
        rd(BASE, d);            chk("spur_mask", d, 16'h00FF);
        rd(BASE + 12'd2, d);    chk("spur_is", d, 16'h0000);
        rd(BASE + 12'd1, d);    chk("spur_pend", d, 16'h0000);

        // Async reset mid-service.
        irq = 8'h04; tick(); irq = 8'h00; tick();
        intack = 1'b1; tick(); intack = 1'b0;
        irq = 8'h02; tick(); irq = 8'h00; tick();
        chk("pre_rst_int", INT, 1);
        rd(BASE + 12'd2, d); chk("pre_rst_is", d, 16'h0004);
        intack = 1'b1; reset = 1'b1; #1;
        chk("arst_int", INT, 0);
        chk("arst_vec", data_rd, 16'hFFFF);
        intack = 1'b0;
        rd(BASE + 12'd2, d); chk("arst_is", d, 16'h0000);
        rd(BASE, d);         chk("arst_mask", d, 16'h0000);
        rd(BASE + 12'd1, d); chk("arst_pend", d, 16'h0000);
        reset = 1'b0;
        tick();

        // Randomized traffic against the reference model.
        reset = 1'b1; #1; reset = 1'b0;
        m_mask = '0; m_pend = '0; m_is = '0; m_prev = '0; m_int = 1'b0;
        irq = '0;
        tick();
        for (int n = 0; n < 3000; n++) begin
            irq     = irq ^ 8'($urandom & $urandom & $urandom);
            intack  = ($urandom_range(0, 3) == 0);
            memwt   = ($urandom_range(0, 3) == 0);
            address = ($urandom_range(0, 15) == 0) ? 12'h9FF : BASE + 12'($urandom_range(0, 9));
            data_wr = 16'($urandom);
            #1;
            chk("rnd_sel", sel, m_sel(address));
            chk("rnd_rd", data_rd, m_rd());
            m_step();
            tick();
            chk("rnd_int", INT, m_int);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
